// File: rtl/row_serializer.sv
`timescale 1ns/1ps
// row_serializer: fetches image-buffer rows one at a time and streams them out
// as individual RGB444 pixels, LSB pixel first, over a valid/ready handshake.
// A single start pulse streams a full frame of NUM_ROWS rows.
module row_serializer #(
    parameter int NUM_PIX  = 256,
    parameter int PIX_W    = 12,
    parameter int NUM_ROWS = 256,
    parameter int ADDR_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [NUM_PIX*PIX_W-1:0] rd_data,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [PIX_W-1:0]         pix_data,
    output logic                     pix_sof,
    output logic                     pix_eol
);

    localparam int CNT_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam logic [CNT_W-1:0]  PIX_LAST = CNT_W'(NUM_PIX - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_SHIFT = 2'd3
    } state_t;

    state_t                   state;
    logic [ADDR_W-1:0]        row_cnt;
    logic [CNT_W-1:0]         pix_cnt;
    logic [NUM_PIX*PIX_W-1:0] shreg;

    // Frame sequencing: fetch a row, capture it, shift it out pixel by pixel.
    // NOTE: every register here uses non-blocking assignment so all state
    // updates take effect together at the clock edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the wide shift register is cleared on reset as well, so a
            // discarded row can never leak out after the block restarts.
            state      <= S_IDLE;
            row_cnt    <= '0;
            pix_cnt    <= '0;
            shreg      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        row_cnt <= '0;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Buffer data arrives one cycle after the read strobe.
                    shreg   <= rd_data;
                    pix_cnt <= '0;
                    state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (pix_ready) begin
                        shreg <= shreg >> PIX_W;
                        if (pix_cnt == PIX_LAST) begin
                            if (row_cnt < ROW_LAST) begin
                                row_cnt <= row_cnt + 1'b1;
                                state   <= S_FETCH;
                            end else begin
                                frame_done <= 1'b1;
                                state      <= S_IDLE;
                            end
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decoded straight from registered state; all zero while idle.
    always_comb begin
        busy      = (state != S_IDLE);
        rd_en     = (state == S_FETCH);
        rd_addr   = rd_en ? row_cnt : '0;
        pix_valid = (state == S_SHIFT);
        pix_data  = pix_valid ? shreg[PIX_W-1:0] : '0;
        pix_sof   = pix_valid && (row_cnt == '0) && (pix_cnt == '0);
        pix_eol   = pix_valid && (pix_cnt == PIX_LAST);
    end

endmodule

// File: tb/tb_row_serializer.sv
`timescale 1ns/1ps
// Bench for row_serializer: a 3-row frame of 256 pixels per row, fed from a
// buffer model, with the pixel stream compared against a row-major list of
// expected pixels and the frame timing derived from the row/pixel counts.
module tb_row_serializer;

    localparam int NUM_PIX  = 256;
    localparam int PIX_W    = 12;
    localparam int NUM_ROWS = 3;
    localparam int ADDR_W   = 8;
    localparam int ROW_CYC  = NUM_PIX + 2;
    localparam int FRAME_PX = NUM_ROWS * NUM_PIX;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic                     busy;
    logic                     frame_done;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic [NUM_PIX*PIX_W-1:0] rd_data = '0;
    logic                     pix_valid;
    logic                     pix_ready;
    logic [PIX_W-1:0]         pix_data;
    logic                     pix_sof;
    logic                     pix_eol;

    int total = 0;
    int bad   = 0;

    logic [PIX_W-1:0]         exp_px [NUM_ROWS][NUM_PIX];
    logic [NUM_PIX*PIX_W-1:0] mem    [NUM_ROWS];

    row_serializer #(
        .NUM_PIX (NUM_PIX),
        .PIX_W   (PIX_W),
        .NUM_ROWS(NUM_ROWS),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .frame_done(frame_done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol)
    );

    always #5 clk = ~clk;

    // Image buffer read port: word valid one cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en && int'(rd_addr) < NUM_ROWS) rd_data <= mem[int'(rd_addr)];
        else                                   rd_data <= '0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {6'd0, busy, frame_done, rd_en, pix_valid, pix_sof, pix_eol, rd_addr, pix_data}, 32'd0);
    endtask

    // Fill the buffer: either row r pixel k = {r[3:0], k[7:0]} or random.
    task automatic fill(input bit rnd);
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int k = 0; k < NUM_PIX; k++) begin
                exp_px[r][k] = rnd ? PIX_W'($urandom) : {4'(r), 8'(k)};
                mem[r][k*PIX_W +: PIX_W] = exp_px[r][k];
            end
        end
    endtask

    // Streams one frame starting at the current negedge and checks it.
    // no_start: start is already high from the previous frame_done cycle.
    task automatic run_frame(input bit no_start, input bit rand_ready,
                             input int busy_start_at, input int rst_after, input bit b2b);
        int cyc, idx, fetches, inv_run, r, k;
        bit stall, done, hs;
        logic [PIX_W-1:0] prev_data;
        logic prev_sof, prev_eol;
        if (!no_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; idx = 0; fetches = 0; inv_run = 0;
        stall = 1'b0; done = 1'b0;
        prev_data = '0; prev_sof = 1'b0; prev_eol = 1'b0;
        while (!done && cyc < 5000) begin
            start     = (cyc == busy_start_at);
            pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            hs        = 1'b0;
            if (rd_en) begin
                check("rd_addr", 32'(rd_addr), fetches);
                if (!rand_ready) check("fetch_cycle", cyc, 1 + fetches * ROW_CYC);
                fetches++;
            end
            if (stall)
                check("hold", {19'd0, pix_valid, pix_data},
                      {19'd0, 1'b1, prev_data});
            if (stall)
                check("hold_flags", {30'd0, pix_sof, pix_eol}, {30'd0, prev_sof, prev_eol});
            if (frame_done) begin
                check("done_pixels", idx, FRAME_PX);
                check("done_fetches", fetches, NUM_ROWS);
                check("done_outputs", {29'd0, busy, pix_valid, rd_en}, 32'd0);
                if (!rand_ready) check("done_cycle", cyc, NUM_ROWS * ROW_CYC + 1);
                done = 1'b1;
                if (b2b) start = 1'b1;
            end else begin
                check("busy", 32'(busy), 32'd1);
            end
            if (!done) begin
                if (pix_valid) begin
                    if (inv_run != 0) check("row_gap", inv_run, 2);
                    inv_run = 0;
                    if (pix_ready) begin
                        hs = 1'b1;
                        if (idx >= FRAME_PX) begin
                            check("extra_pixel", idx, FRAME_PX - 1);
                        end else begin
                            r = idx / NUM_PIX;
                            k = idx % NUM_PIX;
                            check("pix_data", 32'(pix_data), 32'(exp_px[r][k]));
                            check("pix_sof", 32'(pix_sof), 32'(idx == 0));
                            check("pix_eol", 32'(pix_eol), 32'(k == NUM_PIX - 1));
                            if (!rand_ready) check("pix_cycle", cyc, 3 + r * ROW_CYC + k);
                        end
                        idx++;
                    end
                end else begin
                    inv_run++;
                end
                stall     = pix_valid && !pix_ready;
                prev_data = pix_data;
                prev_sof  = pix_sof;
                prev_eol  = pix_eol;
                if (hs && idx == rst_after) begin
                    @(negedge clk);
                    start = 1'b0;
                    rst   = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check_quiet("rst_next_cycle");
                    repeat (4) begin
                        @(negedge clk);
                        check_quiet("rst_idle");
                    end
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        if (!done) check("timeout", 32'd0, 32'd1);
        if (!b2b && rst_after < 0) begin
            start = 1'b0;
            repeat (2) begin
                @(negedge clk);
                check_quiet("post_frame_idle");
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        pix_ready = 1'b0;
        fill(1'b0);
        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("idle_after_reset");

        // Ready tied high: exact pixel timing and frame length.
        run_frame(1'b0, 1'b0, -1, -1, 1'b0);
        // Random data under ~50% backpressure.
        fill(1'b1);
        run_frame(1'b0, 1'b1, -1, -1, 1'b0);
        // Second start mid row 0 is ignored.
        fill(1'b0);
        run_frame(1'b0, 1'b0, 50, -1, 1'b0);
        // Reset right after pixel 100 is accepted.
        run_frame(1'b0, 1'b1, -1, 101, 1'b0);
        // Restream from row 0 pixel 0, then start again in the frame_done cycle.
        run_frame(1'b0, 1'b0, -1, -1, 1'b1);
        run_frame(1'b1, 1'b1, -1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/row_serializer.md
# row_serializer

Reads image rows from the image buffer one row at a time and streams them out as individual 12-bit RGB444 pixels over a valid/ready handshake. It is the read-side counterpart of the row accumulator: each 3072-bit buffer word holds 256 pixels, with pixel 0 in bits [11:0]. The block sits between the image buffer read port and the pixel consumers (display path or coprocessor input). One `start` pulse streams a full frame of `NUM_ROWS` rows.

## Interface

Parameters:
- `NUM_PIX`, 256, pixels per row / buffer word.
- `PIX_W`, 12, pixel width; R [11:8], G [7:4], B [3:0].
- `NUM_ROWS`, 256, rows per frame.
- `ADDR_W`, 8, buffer row address width; must satisfy 2^ADDR_W ≥ NUM_ROWS.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to stream a frame; ignored unless idle.
- `busy` out 1: high from the cycle after `start` is accepted until the cycle after the last pixel handshake.
- `frame_done` out 1: one-cycle pulse after the last pixel of the last row is accepted.
- `rd_en` out 1: image buffer read strobe.
- `rd_addr` out ADDR_W: image buffer row address.
- `rd_data` in NUM_PIX*PIX_W: buffer word, valid exactly one cycle after `rd_en`.
- `pix_valid` out 1: `pix_data` holds a pixel.
- `pix_ready` in 1: consumer accepts the pixel.
- `pix_data` out PIX_W: current pixel.
- `pix_sof` out 1: qualifies pixel 0 of row 0.
- `pix_eol` out 1: qualifies pixel NUM_PIX-1 of any row.

## Operation

- The FSM has four states: IDLE, FETCH, WAIT, SHIFT.
- IDLE:
  - All outputs are 0.
  - `start`=1 sets `row_cnt` to 0 and moves to FETCH.
- FETCH:
  - `rd_en`=1 and `rd_addr`=`row_cnt`.
  - Moves unconditionally to WAIT.
- WAIT:
  - `rd_data` is loaded into the 3072-bit shift register and `pix_cnt` is set to 0.
  - Moves to SHIFT.
- SHIFT:
  - `pix_valid`=1 and `pix_data` = `shreg[PIX_W-1:0]`.
  - On a handshake (`pix_valid & pix_ready`):
    - The shift register shifts right by PIX_W, filling zeros at the top.
    - `pix_cnt` increments.
  - On a handshake when `pix_cnt`=NUM_PIX-1:
    - If `row_cnt` < NUM_ROWS-1: increment `row_cnt` and go to FETCH.
    - Otherwise: pulse `frame_done` next cycle and go to IDLE.
- `pix_sof` = SHIFT & `row_cnt`==0 & `pix_cnt`==0.
- `pix_eol` = SHIFT & `pix_cnt`==NUM_PIX-1.
- Pixel order is LSB first: pixel k is `rd_data[k*PIX_W +: PIX_W]`.
- Backpressure: while `pix_valid` & !`pix_ready`, `pix_data`, `pix_sof`, `pix_eol` and all counters hold. There is no timeout.
- `start` while `busy`=1 is ignored and has no side effects.
- Counter widths: `pix_cnt` is $clog2(NUM_PIX) bits, `row_cnt` is ADDR_W bits. Neither wraps during a frame; both are compared against their terminal values exactly.
- Reset in any state, including mid-row or during FETCH/WAIT:
  - The next state is IDLE.
  - The shift register and counters clear.
  - The current row is discarded and no `frame_done` is issued.
  - `rd_en` is 0 in the cycle after reset is sampled.

## Timing

- Reset values are 0 for `busy`, `frame_done`, `rd_en`, `rd_addr`, `pix_valid`, `pix_data`, `pix_sof` and `pix_eol`. All outputs are registered or decoded directly from registered state.
- Start latency: `start` sampled at edge 0 → FETCH (`rd_en`=1, `rd_addr`=0) in cycle 1 → WAIT in cycle 2 → `pix_valid`=1 with pixel 0 in cycle 3.
- Row-to-row gap: after the last-pixel handshake in cycle T, cycle T+1 is FETCH, T+2 is WAIT, and pixel 0 of the next row is valid in T+3. That is exactly two cycles with `pix_valid`=0.
- Throughput: 1 pixel/cycle inside a row while `pix_ready`=1.
- Frame length with `pix_ready` tied to 1: NUM_ROWS × (NUM_PIX+2) + 1 cycles from `start` to the first `frame_done` cycle.
- `frame_done` is high for exactly one cycle, coincident with the first IDLE cycle.
- `busy` falls in that same cycle.
- A new `start` is accepted in that same cycle.

## Test plan

- **Single row, ready tied high** (NUM_ROWS=1): buffer row 0 = pixel k holds value k[11:0]; pulse `start`.
  - Required: `rd_en`/`rd_addr`=0 in cycle 1.
  - Required: pixels 0x000..0x0FF on consecutive cycles 3..258; `pix_sof` only on pixel 0; `pix_eol` only on 0x0FF.
  - Required: `frame_done` in cycle 259.
- **Backpressure**: toggle `pix_ready` pseudo-randomly (~50%).
  - Required: received pixel sequence identical to the buffer contents.
  - Required: `pix_data` stable whenever `pix_valid` & !`pix_ready`.
- **Multi-row** (NUM_ROWS=3): row r pixel k = {r[3:0], k[7:0]}.
  - Required: `rd_addr` sequence 0,1,2.
  - Required: exactly 2 idle cycles between rows; 768 pixels total.
  - Required: one `frame_done`.
- **Start while busy**: second `start` pulse mid-row 0.
  - Required: no extra `rd_en`; pixel count and `frame_done` count unchanged.
- **Reset mid-row**: assert `rst` after pixel 100 is accepted.
  - Required: next cycle all outputs 0, no `frame_done`.
  - Required: a subsequent `start` restreams from row 0 pixel 0.
- **Back-to-back frames**: `start` in the `frame_done` cycle.
  - Required: new FETCH `rd_addr`=0 in the next cycle.
